uut_clk_ctrl: RTL and testbench
===============================

Name: uut_clk_ctrl

Overview:
- Parametrised successor to the autotest UUT clock generator.
- Replaces the fixed two-ratio divider and clock mux with a programmable clock-enable divider, so the UUT runs on the system clock with a glitch-free enable.
- Sequences the UUT run (reset, run, completion), counts UUT ticks to completion and applies a timeout.
- Sits between the autotest control unit and the UUT.

Parameters:
- DIV_WIDTH, 8: width of the divisor input. Enable period is div+1 clk cycles.
- CNT_WIDTH, 32: width of the tick counter and of timeout_lim.
- RST_TICKS, 4: number of enable ticks rst_uut is held high at run start. Must be at least 1.

Ports:
- clk  in  1: system clock.
- rst  in  1: asynchronous, active-low reset.
- start  in  1: run request, level-sampled in IDLE.
- div  in  DIV_WIDTH: divisor. Latched when start is accepted.
- timeout_lim  in  CNT_WIDTH: maximum run ticks. 0 disables the timeout. Latched with div.
- end_uut  in  1: UUT completion flag.
- clk_en_uut  out  1: UUT clock enable.
- rst_uut  out  1: UUT reset, active-high.
- busy  out  1: high from start acceptance until DONE is entered.
- done  out  1: one-cycle pulse on run completion.
- timeout  out  1: sticky flag, set when the run ends by timeout.
- tick_count  out  CNT_WIDTH: enable ticks counted in RUN.
- sys_count  out  CNT_WIDTH: raw clk cycles in RUN. Present only with the optional feature.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; div_q=0; lim_q=0; divider=0; tick_count=0; sys_count=0. clk_en_uut=0, rst_uut=1, busy=0, done=0, timeout=0.
- The UUT is held in reset whenever the block is idle.
- Divider: active in RST and RUN only.
  - Counter runs 0..div_q and wraps to 0.
  - clk_en_uut=1 in the cycle where counter==div_q (registered output).
  - div_q=0 gives an enable every cycle.
  - Divider clears to 0 on entering RST, so the first tick comes div_q+1 cycles after acceptance.
- IDLE:
  - start=1 latches div→div_q and timeout_lim→lim_q.
  - Clears tick_count, sys_count and timeout; sets busy=1; moves to RST.
- RST:
  - rst_uut=1.
  - Counts RST_TICKS enable ticks. On the last tick, rst_uut drops to 0 in the next cycle and the state moves to RUN.
  - end_uut is ignored in this state.
- RUN:
  - Each enable tick increments tick_count; it saturates at all-ones.
  - end_uut is sampled only in cycles where clk_en_uut=1.
  - end_uut=1 on a tick: the state moves to DONE. That tick is counted.
  - Timeout: lim_q≠0 and tick_count reaches lim_q without end_uut. Set timeout=1 and move to DONE.
  - If end_uut=1 and the timeout limit are reached on the same tick, end_uut wins and timeout stays 0.
- DONE:
  - done=1 for exactly one cycle; busy=0; rst_uut=1; clk_en_uut=0.
  - tick_count and timeout hold their values until the next accepted start.
  - The state moves to IDLE in the next cycle.
- Further inputs:
  - start while busy is ignored.
  - start held high re-triggers from IDLE, so back-to-back runs cost 2 idle cycles.
  - div and timeout_lim changes while busy have no effect.
- Reset mid-run: immediate return to the reset values above, with no done pulse.
- Latency: acceptance to first RUN tick is (RST_TICKS+1)·(div_q+1) cycles.

Optional Feature:
- Macro: UUT_CLK_CTRL_SYSCOUNT_EN.
- When defined:
  - sys_count increments every clk cycle in RUN, saturating.
  - It is cleared on start acceptance and held through DONE and IDLE.
  - Gives the true system-cycle latency independent of div.
- When undefined: sys_count is tied to 0 and the counter logic is not generated.

Decomposition:
- Package uut_clk_ctrl_pkg holds:
  - state_t enum: IDLE, RST, RUN, DONE.
  - Default constants for RST_TICKS and CNT_WIDTH.
- Sub-module clk_en_divider:
  - Parameter DIV_WIDTH.
  - Ports: clk, rst, clr, en, div, tick.
  - Reusable for other enable-driven cores.

Test Plan:
- Reset: rst=0 mid-RUN, div=3 → all outputs return to reset values within the same cycle; no done pulse; rst_uut=1.
- Full rate: div=0, RST_TICKS=4, end_uut rises after the UUT's 10th run tick → first RUN tick 5 cycles after start; done pulse; tick_count=10; timeout=0.
- Divided: div=3, same UUT → clk_en_uut period is 4 cycles; tick_count=10. With the optional feature, sys_count=40.
- Timeout: div=1, timeout_lim=20, end_uut held 0 → timeout=1; tick_count=20; done pulses once.
- Collision and start handling:
  - timeout_lim=10, end_uut=1 on tick 10 → timeout=0, tick_count=10.
  - start pulse while busy → ignored.
  - div changed mid-run → enable period unchanged.
- Back-to-back runs: start held high for 2 runs → second busy rises 2 cycles after the first done; counters cleared; end_uut asserted during RST is ignored.

Source files
------------

// File: rtl/uut_clk_ctrl_pkg.sv
// Shared types and default constants for the UUT clock/run controller.
package uut_clk_ctrl_pkg;

  // Run sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF = 32;
  localparam int RST_TICKS_DEF = 4;

  // The enable divider only runs while the UUT is being reset or run.
  function automatic logic divider_active(input state_t s);
    return (s == RST) || (s == RUN);
  endfunction

endpackage

// File: rtl/uut_clk_ctrl_clk_en_divider.sv
// Programmable clock-enable divider: one registered tick every div+1 cycles.
// The en/clr/div inputs describe the coming cycle, so the tick flop already
// holds the enable for the cycle it is presented in (no glitching decode).
module clk_en_divider #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] cnt_nxt;
  logic                 tick_nxt;

  // Next counter value: restart on clear or when idle, wrap at div.
  always_comb begin
    cnt_nxt  = cnt;
    tick_nxt = 1'b0;
    if (clr) begin
      cnt_nxt = {DIV_WIDTH{1'b0}};
    end else if (!en) begin
      cnt_nxt = {DIV_WIDTH{1'b0}};
    end else if (cnt == div) begin
      cnt_nxt = {DIV_WIDTH{1'b0}};
    end else begin
      cnt_nxt = cnt + DIV_WIDTH'(1);
    end
    tick_nxt = en && (cnt_nxt == div);
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= {DIV_WIDTH{1'b0}};
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= tick_nxt;
    end
  end

endmodule

// File: rtl/uut_clk_ctrl.sv
// UUT clock-enable generator and run sequencer (reset, run, completion,
// tick counting, timeout). Optional raw-cycle counter sys_count is built
// only when UUT_CLK_CTRL_SYSCOUNT_EN is defined; otherwise it reads 0.
module uut_clk_ctrl
  import uut_clk_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int RST_TICKS = RST_TICKS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [CNT_WIDTH-1:0] timeout_lim,
  input  logic                 end_uut,
  output logic                 clk_en_uut,
  output logic                 rst_uut,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] tick_count,
  output logic [CNT_WIDTH-1:0] sys_count
);

  localparam int RW = (RST_TICKS > 1) ? $clog2(RST_TICKS) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic                 hit_timeout;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_nxt;
  logic [CNT_WIDTH-1:0] lim_q;
  logic [RW-1:0]        rst_cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // Saturating successor of the tick counter.
  always_comb begin
    cnt_inc = tick_count;
    if (tick_count == CNT_MAX) begin
      cnt_inc = tick_count;
    end else begin
      cnt_inc = tick_count + CNT_WIDTH'(1);
    end
  end

  // Next-state logic; end_uut is only looked at on RUN ticks and beats the timeout.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    hit_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RST;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      RST: begin
        if (clk_en_uut && (rst_cnt == RST_LAST)) begin
          state_nxt = RUN;
        end else begin
          state_nxt = RST;
        end
      end
      RUN: begin
        if (clk_en_uut && end_uut) begin
          state_nxt = DONE;
        end else if (clk_en_uut && (lim_q != {CNT_WIDTH{1'b0}}) && (cnt_inc == lim_q)) begin
          state_nxt   = DONE;
          hit_timeout = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Divisor seen by the divider for the coming cycle (new value on acceptance).
  always_comb begin
    div_nxt = div_q;
    if (accept) begin
      div_nxt = div;
    end else begin
      div_nxt = div_q;
    end
  end

  clk_en_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (divider_active(state_nxt)),
    .div  (div_nxt),
    .tick (clk_en_uut)
  );

  // State register and run-time latches for divisor and timeout limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      div_q <= {DIV_WIDTH{1'b0}};
      lim_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state <= state_nxt;
      if (accept) begin
        div_q <= div;
        lim_q <= timeout_lim;
      end
    end
  end

  // Reset-phase tick counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_cnt <= {RW{1'b0}};
    end else if (accept) begin
      rst_cnt <= {RW{1'b0}};
    end else if ((state == RST) && clk_en_uut) begin
      rst_cnt <= rst_cnt + RW'(1);
    end
  end

  // Run tick counter and sticky timeout flag; both hold through DONE and IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_count <= {CNT_WIDTH{1'b0}};
      timeout    <= 1'b0;
    end else if (accept) begin
      tick_count <= {CNT_WIDTH{1'b0}};
      timeout    <= 1'b0;
    end else begin
      if ((state == RUN) && clk_en_uut) begin
        tick_count <= cnt_inc;
      end
      if (hit_timeout) begin
        timeout <= 1'b1;
      end
    end
  end

  // Registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_uut <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      rst_uut <= (state_nxt != RUN);
      busy    <= divider_active(state_nxt);
      done    <= (state_nxt == DONE);
    end
  end

`ifdef UUT_CLK_CTRL_SYSCOUNT_EN
  logic [CNT_WIDTH-1:0] sys_cnt;

  // Raw system cycles spent in RUN, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sys_cnt <= {CNT_WIDTH{1'b0}};
    end else if (accept) begin
      sys_cnt <= {CNT_WIDTH{1'b0}};
    end else if ((state == RUN) && (sys_cnt != CNT_MAX)) begin
      sys_cnt <= sys_cnt + CNT_WIDTH'(1);
    end
  end

  assign sys_count = sys_cnt;
`else
  assign sys_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_uut_clk_ctrl.sv
// Directed, table-driven bench for uut_clk_ctrl plus hand-written sequences
// for reset mid-run and back-to-back runs.
module tb_uut_clk_ctrl;

  localparam int DW = 8;
  localparam int CW = 32;
  localparam int RT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] div = '0;
  logic [CW-1:0] timeout_lim = '0;
  logic          end_uut = 1'b0;
  logic          clk_en_uut;
  logic          rst_uut;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] tick_count;
  logic [CW-1:0] sys_count;

  int n_vec = 0;
  int n_bad = 0;

  uut_clk_ctrl #(
    .DIV_WIDTH (DW),
    .CNT_WIDTH (CW),
    .RST_TICKS (RT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .div         (div),
    .timeout_lim (timeout_lim),
    .end_uut     (end_uut),
    .clk_en_uut  (clk_en_uut),
    .rst_uut     (rst_uut),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .tick_count  (tick_count),
    .sys_count   (sys_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] div;
    logic [CW-1:0] lim;
    int            end_tick;   // run tick on which end_uut is raised, 0 = never
    bit            perturb;    // poke start/div/lim mid-run
    int            exp_first;  // cycle of first RUN tick (acceptance = cycle 0)
    int            exp_count;
    bit            exp_to;
    int            exp_period;
    int            exp_sys;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ticks, first, prev, gmin, gmax, done_cnt, done_cyc, rst_fall, busy_low, exp_sys;
    logic [CW-1:0] tc_d, sc_d;
    logic to_d, busy_d, rst_d, en_d;
    string p;
    p = $sformatf("v%0d", idx);
    ticks = 0; first = -1; prev = 0; gmin = 1000000; gmax = 0;
    done_cnt = 0; done_cyc = -1; rst_fall = -1; busy_low = 0;
    tc_d = '0; sc_d = '0; to_d = 1'b0; busy_d = 1'b0; rst_d = 1'b0; en_d = 1'b0;
    div = v.div; timeout_lim = v.lim; end_uut = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      step();
      start = 1'b0;
      end_uut = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc; tc_d = tick_count; to_d = timeout; sc_d = sys_count;
          busy_d = busy; rst_d = rst_uut; en_d = clk_en_uut;
        end
      end else if (done_cyc < 0 && !busy) begin
        busy_low++;
      end
      if (!rst_uut && rst_fall < 0) rst_fall = cyc;
      if (!rst_uut && clk_en_uut) begin
        ticks++;
        if (ticks == 1) begin
          first = cyc;
        end else begin
          if (cyc - prev < gmin) gmin = cyc - prev;
          if (cyc - prev > gmax) gmax = cyc - prev;
        end
        prev = cyc;
        if (ticks == v.end_tick) end_uut = 1'b1;
        if (v.perturb && ticks == 2) begin
          div = 8'd7; timeout_lim = 32'd1; start = 1'b1;
        end
      end
      if (done_cyc > 0 && cyc == done_cyc + 2) break;
    end
    if (done_cyc < 0) begin
      check({p, " done_seen_within_budget"}, 64'd0, 64'd1);
    end else begin
      check({p, " rst_uut_fall_cycle"}, 64'(rst_fall), 64'(RT * v.exp_period + 1));
      check({p, " first_run_tick_cycle"}, 64'(first), 64'(v.exp_first));
      check({p, " run_ticks_seen"}, 64'(ticks), 64'(v.exp_count));
      if (v.exp_count >= 2) begin
        check({p, " min_tick_period"}, 64'(gmin), 64'(v.exp_period));
        check({p, " max_tick_period"}, 64'(gmax), 64'(v.exp_period));
      end
      check({p, " done_cycle"}, 64'(done_cyc),
            64'(v.exp_first + (v.exp_count - 1) * v.exp_period + 1));
      check({p, " done_pulses"}, 64'(done_cnt), 64'd1);
      check({p, " tick_count"}, 64'(tc_d), 64'(v.exp_count));
      check({p, " timeout"}, 64'(to_d), 64'(v.exp_to));
      check({p, " busy_in_done"}, 64'(busy_d), 64'd0);
      check({p, " rst_uut_in_done"}, 64'(rst_d), 64'd1);
      check({p, " clk_en_in_done"}, 64'(en_d), 64'd0);
      check({p, " busy_drops_before_done"}, 64'(busy_low), 64'd0);
      check({p, " tick_count_held_idle"}, 64'(tick_count), 64'(v.exp_count));
      check({p, " timeout_held_idle"}, 64'(timeout), 64'(v.exp_to));
`ifdef UUT_CLK_CTRL_SYSCOUNT_EN
      exp_sys = v.exp_sys;
`else
      exp_sys = 0;
`endif
      check({p, " sys_count"}, 64'(sc_d), 64'(exp_sys));
    end
  endtask

  initial begin
    int done_seen, d1, d2, busy_rise;
    logic [CW-1:0] tc_d1, tc_rise;
    logic busy7;

    //        div    lim     end per first cnt to  period sys
    vt[0] = '{8'd0, 32'd0,  10, 1'b0, 5,  10, 1'b0, 1, 10};
    vt[1] = '{8'd3, 32'd0,  10, 1'b1, 20, 10, 1'b0, 4, 40};
    vt[2] = '{8'd1, 32'd20, 0,  1'b0, 10, 20, 1'b1, 2, 40};
    vt[3] = '{8'd0, 32'd10, 10, 1'b0, 5,  10, 1'b0, 1, 10};
    vt[4] = '{8'd2, 32'd7,  3,  1'b0, 15, 3,  1'b0, 3, 9};
    vt[5] = '{8'd0, 32'd1,  0,  1'b0, 5,  1,  1'b1, 1, 1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset clk_en_uut", 64'(clk_en_uut), 64'd0);
    check("reset rst_uut", 64'(rst_uut), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset timeout", 64'(timeout), 64'd0);
    check("reset tick_count", 64'(tick_count), 64'd0);
    check("reset sys_count", 64'(sys_count), 64'd0);
    rst = 1'b1;
    step();
    check("idle rst_uut", 64'(rst_uut), 64'd1);

    for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

    // Asynchronous reset in the middle of a divided run.
    div = 8'd3; timeout_lim = 32'd0; end_uut = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (24) step();   // cycle 25: RUN, ticks at 20 and 24 counted
    check("midrst pre rst_uut", 64'(rst_uut), 64'd0);
    check("midrst pre tick_count", 64'(tick_count), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    check("midrst clk_en_uut", 64'(clk_en_uut), 64'd0);
    check("midrst rst_uut", 64'(rst_uut), 64'd1);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst tick_count", 64'(tick_count), 64'd0);
    check("midrst sys_count", 64'(sys_count), 64'd0);
    done_seen = 0;
    repeat (3) begin
      step();
      if (done) done_seen++;
    end
    check("midrst no_done_pulse", 64'(done_seen), 64'd0);
    rst = 1'b1;
    step();

    // Back-to-back runs with start held and end_uut high throughout (ignored in RST).
    div = 8'd0; timeout_lim = 32'd0; end_uut = 1'b1; start = 1'b1;
    d1 = -1; d2 = -1; busy_rise = -1; tc_d1 = '0; tc_rise = '1; busy7 = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      step();
      if (cyc == 8) start = 1'b0;
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc; tc_d1 = tick_count;
        end else if (d2 < 0) begin
          d2 = cyc;
        end
      end
      if (d1 > 0 && cyc == d1 + 1) busy7 = busy;
      if (d1 > 0 && busy_rise < 0 && busy) begin
        busy_rise = cyc; tc_rise = tick_count;
      end
    end
    end_uut = 1'b0;
    check("b2b first_done_cycle", 64'(d1), 64'd6);
    check("b2b first_tick_count", 64'(tc_d1), 64'd1);
    check("b2b idle_gap_busy", 64'(busy7), 64'd0);
    check("b2b busy_rise_after_done", 64'(busy_rise - d1), 64'd2);
    check("b2b tick_count_cleared", 64'(tc_rise), 64'd0);
    check("b2b second_done_cycle", 64'(d2), 64'd13);
    check("b2b final_idle_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
